// File: rtl/double_le_arbiter_if.sv
// Requester-side and comparator-side signals of double_le_arbiter.
// master: requesters + comparator; slave: the arbiter.
interface double_le_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [64*N_REQ-1:0] req_a;
  logic [64*N_REQ-1:0] req_b;
  logic [N_REQ-1:0]    rsp_valid;
  logic                rsp_z;
  logic [63:0]         cmp_a;
  logic [63:0]         cmp_b;
  logic                cmp_z;

  modport master (
    output req_valid, req_a, req_b, cmp_z,
    input  req_ready, rsp_valid, rsp_z, cmp_a, cmp_b
  );

  modport slave (
    input  req_valid, req_a, req_b, cmp_z,
    output req_ready, rsp_valid, rsp_z, cmp_a, cmp_b
  );
endinterface

// File: rtl/double_le_arbiter.sv
// Round-robin arbiter sharing one pipelined double_le comparator, with tag tracking of results.
// Define DOUBLE_LE_ARB_FIXED_PRI_EN for fixed lowest-index-wins priority instead of round-robin.
module double_le_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned LATENCY = 2
) (
  input logic                clk,
  input logic                rst,
  double_le_arbiter_if.slave io_bus
);
  localparam int unsigned IdW = $clog2(N_REQ);

  logic [N_REQ-1:0]          w_grant;
  logic [IdW-1:0]            w_gid;
  logic                      w_xfer;
  logic [63:0]               r_cmp_a;
  logic [63:0]               r_cmp_b;
  logic [LATENCY:0]          r_tag_v;
  logic [LATENCY:0][IdW-1:0] r_tag_id;
  logic [N_REQ-1:0]          r_rsp_valid;
  logic                      r_rsp_z;

`ifdef DOUBLE_LE_ARB_FIXED_PRI_EN
  // Scan downwards so the lowest set index is the last one written.
  always_comb begin
    w_gid  = '0;
    w_xfer = 1'b0;
    for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
      if (io_bus.req_valid[k]) begin
        w_gid  = IdW'(k);
        w_xfer = 1'b1;
      end
    end
    if (rst) w_xfer = 1'b0;
  end
`else
  logic [IdW-1:0] r_ptr;
  logic [IdW-1:0] w_cand;

  always_comb begin
    w_gid  = '0;
    w_xfer = 1'b0;
    w_cand = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_cand = IdW'((32'(r_ptr) + k) % N_REQ);
      if (!w_xfer && io_bus.req_valid[w_cand]) begin
        w_gid  = w_cand;
        w_xfer = 1'b1;
      end
    end
    if (rst) w_xfer = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_xfer) begin
      r_ptr <= (32'(w_gid) == N_REQ - 1) ? '0 : w_gid + 1'b1;
    end
  end
`endif

  always_comb begin
    w_grant        = '0;
    w_grant[w_gid] = w_xfer;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmp_a <= '0;
      r_cmp_b <= '0;
    end else if (w_xfer) begin
      r_cmp_a <= io_bus.req_a[64*w_gid +: 64];
      r_cmp_b <= io_bus.req_b[64*w_gid +: 64];
    end
  end

  // Tag stage LATENCY lines up with cmp_z for the operands issued from it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_v  <= '0;
      r_tag_id <= '0;
    end else begin
      r_tag_v[0]  <= w_xfer;
      r_tag_id[0] <= w_gid;
      for (int unsigned i = 1; i <= LATENCY; i++) begin
        r_tag_v[i]  <= r_tag_v[i-1];
        r_tag_id[i] <= r_tag_id[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= '0;
      r_rsp_z     <= 1'b0;
    end else begin
      r_rsp_valid <= '0;
      r_rsp_z     <= 1'b0;
      if (r_tag_v[LATENCY]) begin
        r_rsp_valid[r_tag_id[LATENCY]] <= 1'b1;
        r_rsp_z                        <= io_bus.cmp_z;
      end
    end
  end

  assign io_bus.req_ready = w_grant;
  assign io_bus.cmp_a     = r_cmp_a;
  assign io_bus.cmp_b     = r_cmp_b;
  assign io_bus.rsp_valid = r_rsp_valid;
  assign io_bus.rsp_z     = r_rsp_z;
endmodule

// File: tb/tb_double_le_arbiter.sv
// Directed bench for double_le_arbiter with a behavioural 2-cycle double_le comparator model.
`timescale 1ns/1ps
module tb_double_le_arbiter;
  localparam int unsigned N   = 4;
  localparam int unsigned LAT = 2;

  localparam logic [63:0] D_ONE    = 64'h3FF0000000000000;
  localparam logic [63:0] D_TWO    = 64'h4000000000000000;
  localparam logic [63:0] D_TWO_UP = 64'h4000000000000001;
  localparam logic [63:0] D_1P5    = 64'h3FF8000000000000;
  localparam logic [63:0] D_NEG1   = 64'hBFF0000000000000;
  localparam logic [63:0] D_NAN    = 64'h7FF8000000000000;
  localparam logic [63:0] D_NZ     = 64'h8000000000000000;
  localparam logic [63:0] D_PZ     = 64'h0000000000000000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [LAT-1:0] zp = '0;

  double_le_arbiter_if #(.N_REQ(N)) bus_if ();

  double_le_arbiter #(.N_REQ(N), .LATENCY(LAT)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus_if)
  );

  always #5 clk = ~clk;

  function automatic logic le_ref(input logic [63:0] a, input logic [63:0] b);
    if ((a[62:52] == 11'h7FF && a[51:0] != 52'd0) || (b[62:52] == 11'h7FF && b[51:0] != 52'd0))
      return 1'b0;
    if (a[62:0] == 63'd0 && b[62:0] == 63'd0) return 1'b1;
    if (a[63] != b[63]) return a[63];
    if (!a[63]) return a[62:0] <= b[62:0];
    return a[62:0] >= b[62:0];
  endfunction

  // Comparator: result valid LAT cycles after its operands appear.
  always @(posedge clk) begin
    zp[0] <= le_ref(bus_if.cmp_a, bus_if.cmp_b);
    zp[1] <= zp[0];
  end
  assign bus_if.cmp_z = zp[LAT-1];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input logic [3:0] v, input logic z);
    chk4({tag, "_valid"}, bus_if.rsp_valid, v);
    chk4({tag, "_z"}, {3'b000, bus_if.rsp_z}, {3'b000, z});
  endtask

  task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b);
    bus_if.req_a[64*i +: 64] = a;
    bus_if.req_b[64*i +: 64] = b;
  endtask

  int   gap_iss [4] = '{0, 2, 5, 11};
  logic gap_z   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    logic [3:0] exp_v;
    logic       exp_z;
    bus_if.req_valid = '0;
    bus_if.req_a     = '0;
    bus_if.req_b     = '0;

    // Reset state
    step();
    bus_if.req_valid = 4'hF;
    #1;
    chk4("rst_ready", bus_if.req_ready, 4'b0000);
    chk_rsp("rst_rsp", 4'b0000, 1'b0);
    chk64("rst_cmp_a", bus_if.cmp_a, 64'd0);
    chk64("rst_cmp_b", bus_if.cmp_b, 64'd0);
    bus_if.req_valid = '0;
    step();
    rst = 1'b0;
    repeat (3) step();

    // Single compare from requester 0
    set_req(0, D_ONE, D_TWO);
    bus_if.req_valid = 4'b0001;
    #1;
    chk4("single_ready", bus_if.req_ready, 4'b0001);
    step();
    bus_if.req_valid = '0;
    chk64("single_cmp_a", bus_if.cmp_a, D_ONE);
    chk64("single_cmp_b", bus_if.cmp_b, D_TWO);
    chk_rsp("single_t1", 4'b0000, 1'b0);
    step(); chk_rsp("single_t2", 4'b0000, 1'b0);
    step(); chk_rsp("single_t3", 4'b0000, 1'b0);
    step(); chk_rsp("single_t4", 4'b0001, 1'b1);
    step(); chk_rsp("single_t5", 4'b0000, 1'b0);

    // Special values: NaN and signed zeros
    set_req(2, D_NAN, D_ONE);
    bus_if.req_valid = 4'b0100;
    #1;
    chk4("nan_ready", bus_if.req_ready, 4'b0100);
    step();
    set_req(1, D_NZ, D_PZ);
    bus_if.req_valid = 4'b0010;
    #1;
    chk4("zero_ready", bus_if.req_ready, 4'b0010);
    step();
    bus_if.req_valid = '0;
    chk_rsp("spec_t2", 4'b0000, 1'b0);
    step(); chk_rsp("spec_t3", 4'b0000, 1'b0);
    step(); chk_rsp("spec_nan", 4'b0100, 1'b0);
    step(); chk_rsp("spec_zero", 4'b0010, 1'b1);
    step(); chk_rsp("spec_after", 4'b0000, 1'b0);

    // Reset with three compares in flight
    set_req(3, D_ONE, D_TWO);
    bus_if.req_valid = 4'b1000;
    #1;
    chk4("flight_g3", bus_if.req_ready, 4'b1000);
    step();
    set_req(0, D_ONE, D_TWO);
    bus_if.req_valid = 4'b0001;
    #1;
    chk4("flight_g0", bus_if.req_ready, 4'b0001);
    step();
    set_req(1, D_ONE, D_TWO);
    bus_if.req_valid = 4'b0010;
    #1;
    chk4("flight_g1", bus_if.req_ready, 4'b0010);
    step();
    bus_if.req_valid = 4'hF;
    rst = 1'b1;
    #1;
    chk4("flight_rst_ready", bus_if.req_ready, 4'b0000);
    chk64("flight_rst_cmp_a", bus_if.cmp_a, 64'd0);
    chk_rsp("flight_rst_rsp", 4'b0000, 1'b0);
    step(); chk_rsp("flight_rst_rsp2", 4'b0000, 1'b0);
    step();
    bus_if.req_valid = '0;
    rst = 1'b0;
    repeat (8) begin
      step();
      chk_rsp("flight_flush", 4'b0000, 1'b0);
    end

    // Round-robin from ptr 0 with all four requesters
    set_req(0, D_ONE, D_TWO);
    set_req(1, D_TWO, D_ONE);
    set_req(2, D_NEG1, D_ONE);
    set_req(3, D_ONE, D_NEG1);
    bus_if.req_valid = 4'b1110;
    #1;
    chk4("post_rst_low", bus_if.req_ready, 4'b0010);
    bus_if.req_valid = 4'b1111;
    #1;
    chk4("post_rst_all", bus_if.req_ready, 4'b0001);
    for (int c = 0; c < 11; c++) begin
`ifdef DOUBLE_LE_ARB_FIXED_PRI_EN
      if (c < 6) chk4("rr_grant", bus_if.req_ready, 4'b0001);
      if (c >= 4 && c < 10) chk_rsp("rr_rsp", 4'b0001, 1'b1);
      else chk_rsp("rr_quiet", 4'b0000, 1'b0);
`else
      if (c < 6) chk4("rr_grant", bus_if.req_ready, 4'(1 << (c % 4)));
      if (c >= 4 && c < 10) chk_rsp("rr_rsp", 4'(1 << ((c - 4) % 4)), ((c - 4) % 2) == 0);
      else chk_rsp("rr_quiet", 4'b0000, 1'b0);
`endif
      if (c == 1) chk64("rr_cmp_a", bus_if.cmp_a, D_ONE);
      step();
      if (c == 5) bus_if.req_valid = '0;
    end

    // Requester 3 holds its operands while requester 2 is served
    set_req(2, D_TWO, D_TWO);
    set_req(3, D_TWO_UP, D_TWO);
    bus_if.req_valid = 4'b1100;
    #1;
    chk4("hold_g2", bus_if.req_ready, 4'b0100);
    step();
    bus_if.req_valid = 4'b1000;
    #1;
    chk4("hold_g3", bus_if.req_ready, 4'b1000);
    chk64("hold_cmp_a2", bus_if.cmp_a, D_TWO);
    step();
    bus_if.req_valid = '0;
    chk64("hold_cmp_a3", bus_if.cmp_a, D_TWO_UP);
    chk_rsp("hold_t2", 4'b0000, 1'b0);
    step(); chk_rsp("hold_t3", 4'b0000, 1'b0);
    step(); chk_rsp("hold_rsp2", 4'b0100, 1'b1);
    step(); chk_rsp("hold_rsp3", 4'b1000, 1'b0);
    step(); chk_rsp("hold_after", 4'b0000, 1'b0);

    // Idle gaps of 1, 2 and 5 cycles between requests
    for (int c = 0; c < 17; c++) begin
      bus_if.req_valid = '0;
      for (int j = 0; j < 4; j++) begin
        if (gap_iss[j] == c) begin
          set_req(1, (j % 2 == 0) ? D_ONE : D_TWO, D_1P5);
          bus_if.req_valid = 4'b0010;
        end
      end
      #1;
      if (bus_if.req_valid != 4'b0000) chk4("gap_grant", bus_if.req_ready, 4'b0010);
      exp_v = 4'b0000;
      exp_z = 1'b0;
      for (int j = 0; j < 4; j++) begin
        if (gap_iss[j] + int'(LAT) + 2 == c) begin
          exp_v = 4'b0010;
          exp_z = gap_z[j];
        end
      end
      chk_rsp("gap_rsp", exp_v, exp_z);
      step();
    end
    bus_if.req_valid = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/double_le_arbiter.md
# double_le_arbiter

Round-robin arbiter and tag scheduler sharing one pipelined `double_le` comparator among `N_REQ` requesters. Accepts at most one compare per cycle, drives the comparator operands from a register stage, and tracks each issued operation's requester ID alongside the comparator pipeline. Routes each result back as a single-cycle response pulse to the requester that issued it. Sits between multiple sort/select engines and a single `double_le` instance.

## Interface

Parameters:
- `N_REQ`, default 4: number of requesters, 2..16.
- `LATENCY`, default 2: cycles from `cmp_a`/`cmp_b` change to the matching `cmp_z` on the attached comparator.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `req_valid`, input, `N_REQ`: per-requester request valid.
- `req_ready`, output, `N_REQ`: per-requester grant. One-hot or zero; combinational from `req_valid` and the priority pointer.
- `req_a`, input, `64*N_REQ`: operand a per requester, IEEE-754 double. Requester i uses bits `[64i+63:64i]`.
- `req_b`, input, `64*N_REQ`: operand b per requester, same packing.
- `rsp_valid`, output, `N_REQ`: one-cycle result pulse, at most one bit set.
- `rsp_z`, output, 1: result `a <= b`, meaningful only while `rsp_valid` is nonzero, 0 otherwise.
- `cmp_a`, output, 64: operand a to the comparator.
- `cmp_b`, output, 64: operand b to the comparator.
- `cmp_z`, input, 1: comparator result.

## Operation

- **Handshake:** a transfer for requester i occurs in cycle t when `req_valid[i] & req_ready[i]`. A requester holds `a`/`b` stable while valid and not ready. Responses cannot be back-pressured.
- **Arbitration:**
  - `ptr` is a register in `0..N_REQ-1`.
  - The grant goes to the first requester with valid set, searching `ptr, ptr+1, …` with wrap-around modulo `N_REQ`.
  - After a grant to requester g, `ptr` becomes `(g+1) mod N_REQ`.
  - With no valid requester, `ptr` is unchanged and no `req_ready` bit is set.
- **Issue register:** on a transfer, `cmp_a`/`cmp_b` load the granted operands at the next edge. With no transfer they hold their previous value.
- **Tag pipeline:**
  - A shift register of depth `LATENCY+1` carries a valid bit and a `$clog2(N_REQ)`-bit ID.
  - Stage 0 loads `{transfer, g}`. Each following stage shifts every cycle.
- **Response register:** at each edge, with tag stage `LATENCY` valid and ID k:
  - `rsp_valid` loads the one-hot bit for k;
  - `rsp_z` loads `cmp_z`.
  
  Otherwise both load 0.
- **Throughput:** one issue per cycle, sustained. A single requester holding valid continuously is granted every cycle.
- **Simultaneous events:** new issue and response in the same cycle are independent. A requester may receive a response and be granted again in the same cycle.
- **Reset:**
  - Clears `ptr`, all tag valids, `cmp_a`, `cmp_b`, `rsp_valid` and `rsp_z` to 0.
  - `req_ready` is 0 while `rst` is high.
  - Reset mid-operation discards all in-flight compares. No response is ever produced for them.

## Timing

- Transfer in cycle t: `cmp_a`/`cmp_b` valid from t+1, `cmp_z` valid in cycle t+1+`LATENCY`, `rsp_valid`/`rsp_z` high for exactly cycle t+2+`LATENCY`. Total latency is `LATENCY+2` cycles (4 by default).
- Responses return in issue order, one per cycle at most.
- `req_ready` depends combinationally on `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_z`=0, `cmp_a`=0, `cmp_b`=0.

## Configuration

- `DOUBLE_LE_ARB_FIXED_PRI_EN` defined:
  - Fixed priority, lowest index wins.
  - `ptr` is removed. The grant is the lowest set bit of `req_valid`.
- Not defined: round-robin as described above.
- Latency and response behaviour are identical in both builds.

## Test plan

- **Single compare:** requester 0 issues a=0x3FF0000000000000 (1.0), b=0x4000000000000000 (2.0) at cycle 10 → `cmp_a`=0x3FF0… at cycle 11; `rsp_valid`=4'b0001, `rsp_z`=1 at cycle 14 only.
- **Round-robin:** all four requesters valid continuously from `ptr`=0 → grants in order 0,1,2,3,0,… one per cycle. Responses appear in the same order starting 4 cycles after the first grant. With `DOUBLE_LE_ARB_FIXED_PRI_EN` defined, requester 0 is granted every cycle.
- **Special values:** requester 2 issues a=0x7FF8000000000000 (NaN), b=0x3FF0000000000000 → `rsp_z`=0. Requester 1 issues a=0x8000000000000000 (-0.0), b=0x0000000000000000 (+0.0) → `rsp_z`=1.
- **Hold stability:** requester 3 valid with operands held while requester 2 is being granted → requester 3 is granted next cycle and its response carries its own operands' result.
- **Reset mid-flight:** issue 3 compares on consecutive cycles, assert `rst` the cycle after the last → no `rsp_valid` pulse ever appears for them; `ptr`=0 after release; the first new grant goes to the lowest valid index.
- **Idle gaps:** requests separated by 1, 2 and 5 idle cycles → each response occurs exactly `LATENCY+2` cycles after its transfer; `rsp_valid` and `rsp_z` stay 0 in all other cycles.
